gol_led_scan: RTL

//  Downstream display stage for the Game of Life engine: accepts each 64-bit generation grid over a

---
 rtl/gol_led_scan.sv | 124 ++++++++++++
 1 files changed

// File: rtl/gol_led_scan.sv
// Game of Life display stage: latches each generation grid over valid/ready and
// row-multiplexes it onto an 8x8 LED matrix, swapping buffers only at frame boundaries.
module gol_led_scan #(
   parameter int CLK_DIV        = 1000,
   parameter int BLANK_CYCLES   = 2,
   parameter bit ROW_ACTIVE_LOW = 1'b1,
   parameter bit COL_ACTIVE_LOW = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [63:0] grid_in,
   input  logic        grid_valid,
   output logic        grid_ready,
   output logic [7:0]  row_out,
   output logic [7:0]  col_out,
   output logic        frame_done
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [7:0]    ROW_OFF    = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [7:0]    COL_OFF    = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t         state;
   logic [2:0]     row;
   logic [CW-1:0]  cnt;
   logic [63:0]    disp;
   logic [63:0]    pending;
   logic           pend_full;
   logic           accept;
   logic           xfer;
   logic           start;
   logic           frame_wrap;

   // XOR against the off level flips polarity without a separate mux per pin.
   function automatic logic [7:0] row_drive(input logic [2:0] r);
      return ROW_OFF ^ (8'b1 << r);
   endfunction

   // Row r occupies grid bits [63-8r -: 8]; ~r * 8 is the low end of that slice.
   function automatic logic [7:0] col_drive(input logic [63:0] g, input logic [2:0] r);
      return COL_OFF ^ g[{~r, 3'b000} +: 8];
   endfunction

   assign accept     = grid_valid && grid_ready;
   assign start      = enable && (state == IDLE);
   assign frame_wrap = enable && (state == DRIVE) && (row == 3'd7) && (cnt == CNT_LAST);
   assign xfer       = pend_full && (start || frame_wrap);

   // NOTE: every register here uses <= so all updates see the pre-edge values;
   // the buffers are reset too, since a blank display after reset is required behaviour.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         row        <= 3'd0;
         cnt        <= '0;
         disp       <= 64'd0;
         pending    <= 64'd0;
         pend_full  <= 1'b0;
         grid_ready <= 1'b1;
         row_out    <= ROW_OFF;
         col_out    <= COL_OFF;
         frame_done <= 1'b0;
      end else begin
         // ready mirrors pend_full, so accept and xfer can never fire together.
         if (accept) begin
            pending    <= grid_in;
            pend_full  <= 1'b1;
            grid_ready <= 1'b0;
         end else if (xfer) begin
            pend_full  <= 1'b0;
            grid_ready <= 1'b1;
         end
         if (xfer)
            disp <= pending;

         frame_done <= 1'b0;
         if (!enable) begin
            state   <= IDLE;
            row     <= 3'd0;
            cnt     <= '0;
            row_out <= ROW_OFF;
            col_out <= COL_OFF;
         end else begin
            case (state)
               IDLE: begin
                  state   <= BLANK;
                  row     <= 3'd0;
                  cnt     <= '0;
                  row_out <= ROW_OFF;
                  col_out <= COL_OFF;
               end
               BLANK: begin
                  cnt <= cnt + CW'(1);
                  if (cnt == BLANK_LAST) begin
                     state      <= DRIVE;
                     row_out    <= row_drive(row);
                     col_out    <= col_drive(disp, row);
                     frame_done <= (row == 3'd7) && (cnt + CW'(1) == CNT_LAST);
                  end
               end
               DRIVE: begin
                  if (cnt == CNT_LAST) begin
                     state   <= BLANK;
                     cnt     <= '0;
                     row     <= row + 3'd1;
                     row_out <= ROW_OFF;
                     col_out <= COL_OFF;
                  end else begin
                     cnt        <= cnt + CW'(1);
                     frame_done <= (row == 3'd7) && (cnt + CW'(1) == CNT_LAST);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
